// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial 2-bit-slice adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_add_pkg;

  // Number of operand bits consumed per RUN cycle.
  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder2.sv
// 2-bit ripple adder cell: {Cout, SUM} = A + B + Cin.
// Latency: combinational, zero cycles.
// Backpressure: none (pure logic).
//
// Ports:
//   A, B  2-bit addends
//   Cin   carry into bit 0
//   SUM   2-bit sum
//   Cout  carry out of bit 1
module adder2 (
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       Cin,
  output logic [1:0] SUM,
  output logic       Cout
);

  logic c0;

  // Explicit ripple through bit 0 into bit 1.
  assign SUM[0] = A[0] ^ B[0] ^ Cin;
  assign c0     = (A[0] & B[0]) | (Cin & (A[0] ^ B[0]));
  assign SUM[1] = A[1] ^ B[1] ^ c0;
  assign Cout   = (A[1] & B[1]) | (c0 & (A[1] ^ B[1]));

endmodule

// File: rtl/serial_add_seq.sv
// Serial adder: sums one WIDTH-bit word two bits per cycle, LSB slice first.
// Latency: out_valid rises WIDTH/2 clock edges after the edge accepting a word.
// Backpressure: one word in flight; in_ready only in IDLE, result held until out_ready.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake; in_a, in_b, in_cin captured on accept
//   out_valid/out_ready  result handshake; out_sum, out_cout stable while waiting
//   out_ovf              signed overflow, only when SERIAL_ADD_OVF_EN is defined
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   a_nxt;
  logic               carry;
  logic [CW-1:0]      cnt;
  logic [SLICE_W-1:0] s_slice;
  logic               c_slice;
  logic               accept;
  logic               run_last;

`ifdef SERIAL_ADD_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  adder2 u_add (
    .A    (a_sr[SLICE_W-1:0]),
    .B    (b_sr[SLICE_W-1:0]),
    .Cin  (carry),
    .SUM  (s_slice),
    .Cout (c_slice)
  );

  // The A shift register doubles as the result register: every consumed
  // slice frees the top SLICE_W positions, which the new sum slice fills.
  // After NSLICE shifts it holds the complete sum.
  if (WIDTH > SLICE_W) begin : g_wide
    assign a_nxt = {s_slice, a_sr[WIDTH-1:SLICE_W]};
  end else begin : g_narrow
    assign a_nxt = s_slice;
  end

  assign accept   = in_ready && in_valid;
  assign run_last = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      out_ovf  <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= in_a;
      b_sr  <= in_b;
      carry <= in_cin;
      cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      a_msb <= in_a[WIDTH-1];
      b_msb <= in_b[WIDTH-1];
`endif
    end else if (state == RUN) begin
      a_sr  <= a_nxt;
      b_sr  <= b_sr >> SLICE_W;
      carry <= c_slice;
      cnt   <= cnt + 1'b1;
      // Outputs update only when the word completes, so they keep the
      // previous result through IDLE and RUN.
      if (run_last) begin
        out_sum  <= a_nxt;
        out_cout <= c_slice;
`ifdef SERIAL_ADD_OVF_EN
        out_ovf  <= (a_msb == b_msb) && (a_nxt[WIDTH-1] != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq (WIDTH=8).
// Latency: checks out_valid arrives WIDTH/2 edges after acceptance.
// Backpressure: exercises out_ready stalls and ignored in_valid during RUN/DONE.
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         out_ovf;
  logic         ovf_q[$];
`endif

  int checks   = 0;
  int failures = 0;

  // Expected {cout, sum} per word, pushed when the word is driven.
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input bit push);
    int n = 0;
    logic [W:0] t;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_in_ready", 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    if (push) begin
      t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      sb.push_back(t);
`ifdef SERIAL_ADD_OVF_EN
      ovf_q.push_back((a[W-1] == b[W-1]) && (t[W-1] != a[W-1]));
`endif
    end
    @(negedge clk);
    // Scramble operands after acceptance; the word in flight must not see it.
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_cin   = 1'($urandom);
  endtask

  task automatic recv(input int stall, input bit poke);
    int lat = 0;
    logic [W-1:0] s0;
    logic [W:0]   e;
    while (!out_valid && lat < 50) begin
      if (poke) begin
        in_valid = 1'b1;
        in_a     = 8'h11;
        in_b     = 8'h11;
        chk("run_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      lat++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    chk("latency", 32'(lat), 32'(W / 2));
    s0 = out_sum;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(out_sum), 32'(s0));
      if (poke) chk("done_in_ready", 32'(in_ready), 32'd0);
    end
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("sum", 32'(out_sum), 32'(e[W-1:0]));
    chk("cout", 32'(out_cout), 32'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
    if (ovf_q.size() > 0) chk("ovf", 32'(out_ovf), 32'(ovf_q.pop_front()));
`endif
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed words.
    send(8'h5A, 8'h3C, 1'b0, 1'b1); recv(0, 1'b0);
    send(8'hFF, 8'h01, 1'b0, 1'b1); recv(0, 1'b0);
    send(8'hFF, 8'h00, 1'b1, 1'b1); recv(0, 1'b0);
    send(8'h80, 8'h80, 1'b0, 1'b1); recv(0, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 1'b1); recv(0, 1'b0);

    // Five-cycle output stall with in_valid poked during RUN and DONE.
    send(8'h12, 8'h34, 1'b1, 1'b1); recv(5, 1'b1);

    // Reset during the second RUN cycle aborts the word.
    send(8'hA5, 8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_sum", 32'(out_sum), 32'd0);
    chk("abort_out_cout", 32'(out_cout), 32'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    send(8'h01, 8'h02, 1'b0, 1'b1); recv(0, 1'b0);

    // Random back-to-back words with random output stalls.
    for (int k = 0; k < 1000; k++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      recv($urandom_range(0, 3), 1'b0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand/sum width in bits; SHALL be an even number >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  operand word valid.
REQ-005 in_ready  output  1  block can accept an operand word.
REQ-006 in_a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 in_b  input  WIDTH  operand B.
REQ-008 in_cin  input  1  carry-in for bit 0.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_sum  output  WIDTH  in_a + in_b + in_cin, mod 2^WIDTH.
REQ-012 out_cout  output  1  carry out of bit WIDTH-1.
REQ-013 out_ovf  output  1  signed overflow; present only when SERIAL_ADD_OVF_EN is defined.

Function
REQ-014 FSM states: IDLE, RUN, DONE; encoding is implementation choice.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1, SHALL capture in_a, in_b and in_cin into the operand shift registers and carry register, clear the slice counter, and go to RUN.
REQ-016 RUN: in_ready=0, out_valid=0; each cycle SHALL add the current 2-bit slices (LSB slice first) plus the carry register, shift the 2-bit sum into the result register from the MSB end, update the carry register, and increment the slice counter.
REQ-017 RUN SHALL last exactly WIDTH/2 cycles, then go to DONE; out_valid SHALL be high exactly WIDTH/2 clock edges after the accepting edge (4 for WIDTH=8).
REQ-018 DONE: out_valid=1; out_sum, out_cout (and out_ovf) SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 DONE with out_ready=1: go to IDLE at that edge; in_ready SHALL not be asserted in DONE (no same-cycle reload).
REQ-020 in_valid in RUN or DONE SHALL be ignored; operands are not captured.
REQ-021 in_a/in_b/in_cin changes after acceptance SHALL not affect the result in progress.
REQ-022 Carry SHALL ripple across slice boundaries through the carry register only; no carry is lost at wrap of the counter.
REQ-023 out_sum/out_cout SHALL hold their last values in IDLE and RUN, but they are defined only while out_valid=1.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, and clear the counter, carry, operand and result registers, out_sum=0, out_cout=0, out_ovf=0, out_valid=0.
REQ-025 After the reset edge, in_ready SHALL be 1.
REQ-026 Reset in RUN or DONE SHALL abort the operation; no out_valid pulse SHALL follow for the aborted word.

Configuration
REQ-027 Macro SERIAL_ADD_OVF_EN.
- Defined: out_ovf port exists; MSBs of A and B are captured at acceptance; out_ovf = (A[W-1]==B[W-1]) && (out_sum[W-1]!=A[W-1]), valid with out_valid.
- Undefined: no out_ovf port, no MSB capture logic; all other behaviour identical.

Structure
REQ-028 Shared package serial_add_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the slice width constant SLICE_W=2.
REQ-029 The per-cycle 2-bit slice addition SHALL use one instance of the existing 2-bit ripple adder cell adder2 (Cout, SUM[1:0], A[1:0], B[1:0], Cin); no other sub-modules.
REQ-030 Slice counter width SHALL be $clog2(WIDTH/2) bits, minimum 1 bit.

Verification (WIDTH=8)
REQ-031 a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, ovf=1; out_valid 4 edges after accept.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-033 a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1; a=0x7F, b=0x01 -> sum=0x80, ovf=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_sum stable for 5 cycles; in_valid pulses during RUN/DONE with a=0x11 are not captured.
REQ-035 rst_n=0 during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, outputs 0; a new word 0x01+0x02 then yields 0x03.
REQ-036 Random back-to-back words (>=1000, random out_ready stalls) checked against a reference model of a+b+cin.
